// File: rtl/blake2_host_driver.sv
// blake2_host_driver
//   Host-side driver for the BLAKE2s accelerator pin interface. On start it
//   sends a 4-byte config frame. It then streams the message, zero-padded to
//   64-byte blocks and marked last-block on the final block. Finally it
//   collects the digest bytes returned by the accelerator.
// Ports
//   clk, reset             : clock, async active-high reset
//   start_i, nn_i, ll_i    : request, digest length (1..32), message length
//   s_data_i/s_valid_i/s_ready_o : upstream message byte stream
//   data_o/valid_o/cmd_o   : registered byte to accelerator (ui_in / uio_in)
//   ready_i                : accelerator accepts byte when valid_o & ready_i
//   hash_valid_i, hash_i   : digest byte from accelerator
//   m_data_o/m_valid_o     : captured digest byte, 1-cycle latency
//   done_o, error_o        : completion pulse, sticky error flag
module blake2_host_driver #(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_i,
   input  logic [5:0]  nn_i,
   input  logic [15:0] ll_i,
   input  logic [7:0]  s_data_i,
   input  logic        s_valid_i,
   output logic        s_ready_o,
   output logic [7:0]  data_o,
   output logic        valid_o,
   output logic [1:0]  cmd_o,
   input  logic        ready_i,
   input  logic        hash_valid_i,
   input  logic [7:0]  hash_i,
   output logic [7:0]  m_data_o,
   output logic        m_valid_o,
   output logic        done_o,
   output logic        error_o
);

   typedef enum logic [2:0] {S_IDLE, S_CFG, S_DATA, S_PAD, S_WAIT, S_HASH} state_t;

   state_t      r_state, w_state_nxt;
   logic [5:0]  r_nn, r_byte_idx, r_hash_cnt;
   logic [15:0] r_ll;
   logic [16:0] r_sent_cnt, r_block_base;
   logic [1:0]  r_cfg_idx;
   logic [12:0] r_tmo;

   logic       w_can_load, w_last_blk, w_nn_ok, w_tmo_hit;
   logic [1:0] w_cmd_blk;
   logic       w_load, w_accept, w_err_set, w_err_clr, w_cap, w_done;
   logic [7:0] w_load_data;
   logic [1:0] w_load_cmd;

   // Output register may take a new byte when empty or draining this cycle.
   assign w_can_load = ~valid_o | ready_i;
   // Block marking is decided from the block's base offset, so every byte of
   // a block (data and pad) carries the same cmd.
   assign w_last_blk = (r_ll == 16'd0) | (({1'b0, r_ll} - r_block_base) <= 17'd64);
   assign w_cmd_blk  = w_last_blk ? 2'd2 : 2'd1;
   assign w_nn_ok    = (nn_i != 6'd0) && (nn_i <= 6'd32);
   assign w_tmo_hit  = (r_tmo == 13'(TIMEOUT_CYCLES - 1));
   assign s_ready_o  = (r_state == S_DATA) & w_can_load & (r_sent_cnt < {1'b0, r_ll});

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_load_data = 8'h00;
      w_load_cmd  = 2'd0;
      w_accept    = 1'b0;
      w_err_set   = 1'b0;
      w_err_clr   = 1'b0;
      w_cap       = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               if (w_nn_ok) begin
                  w_accept    = 1'b1;
                  w_err_clr   = 1'b1;
                  w_state_nxt = S_CFG;
               end else begin
                  w_err_set = 1'b1;
               end
            end
         end
         S_CFG: begin
            if (w_can_load) begin
               w_load = 1'b1;
               case (r_cfg_idx)
                  2'd0:    w_load_data = 8'h00;
                  2'd1:    w_load_data = {2'b00, r_nn};
                  2'd2:    w_load_data = r_ll[7:0];
                  default: w_load_data = r_ll[15:8];
               endcase
               if (r_cfg_idx == 2'd3) w_state_nxt = (r_ll != 16'd0) ? S_DATA : S_PAD;
            end
         end
         S_DATA: begin
            if (s_ready_o & s_valid_i) begin
               w_load      = 1'b1;
               w_load_data = s_data_i;
               w_load_cmd  = w_cmd_blk;
               if ((r_sent_cnt + 17'd1) == {1'b0, r_ll})
                  w_state_nxt = (r_byte_idx == 6'd63) ? S_WAIT : S_PAD;
            end
         end
         S_PAD: begin
            if (w_can_load) begin
               w_load     = 1'b1;
               w_load_cmd = w_cmd_blk;
               if (r_byte_idx == 6'd63) w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (hash_valid_i) begin
               w_cap = 1'b1;
               if (r_nn == 6'd1) begin
                  w_done      = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_state_nxt = S_HASH;
               end
            end else if (~valid_o & w_tmo_hit) begin
               w_err_set   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_HASH: begin
            if (hash_valid_i) begin
               w_cap = 1'b1;
               if ((r_hash_cnt + 6'd1) == r_nn) begin
                  w_done      = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_err_set   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      // A digest byte before the stream is complete is a protocol error.
      if (hash_valid_i && (r_state == S_IDLE || r_state == S_CFG ||
                           r_state == S_DATA || r_state == S_PAD))
         w_err_set = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_nn         <= '0;
         r_ll         <= '0;
         r_cfg_idx    <= '0;
         r_sent_cnt   <= '0;
         r_byte_idx   <= '0;
         r_block_base <= '0;
         r_tmo        <= '0;
         r_hash_cnt   <= '0;
         data_o       <= '0;
         valid_o      <= 1'b0;
         cmd_o        <= '0;
         m_data_o     <= '0;
         m_valid_o    <= 1'b0;
         done_o       <= 1'b0;
         error_o      <= 1'b0;
      end else begin
         m_valid_o <= 1'b0;
         done_o    <= w_done;
         if (w_err_clr) error_o <= 1'b0;
         if (w_err_set) error_o <= 1'b1;
         if (w_accept) begin
            r_nn         <= nn_i;
            r_ll         <= ll_i;
            r_cfg_idx    <= '0;
            r_sent_cnt   <= '0;
            r_byte_idx   <= '0;
            r_block_base <= '0;
            r_tmo        <= '0;
            r_hash_cnt   <= '0;
         end
         if (w_load) begin
            data_o  <= w_load_data;
            cmd_o   <= w_load_cmd;
            valid_o <= 1'b1;
         end else if (ready_i) begin
            valid_o <= 1'b0;
         end
         if (w_load && r_state == S_CFG) r_cfg_idx <= r_cfg_idx + 2'd1;
         if (w_load && r_state != S_CFG) begin
            r_byte_idx <= r_byte_idx + 6'd1;
            if (r_byte_idx == 6'd63) r_block_base <= r_block_base + 17'd64;
         end
         if (w_load && r_state == S_DATA) r_sent_cnt <= r_sent_cnt + 17'd1;
         // Timeout counts from the cycle the last byte has left the output register.
         if (r_state == S_WAIT && ~hash_valid_i && ~valid_o) r_tmo <= r_tmo + 13'd1;
         if (w_cap) begin
            m_data_o   <= hash_i;
            m_valid_o  <= 1'b1;
            r_hash_cnt <= r_hash_cnt + 6'd1;
         end
      end
   end

endmodule

// File: tb/tb_blake2_host_driver.sv
module tb_blake2_host_driver;
   logic        clk = 1'b0;
   logic        reset;
   logic        start_i;
   logic [5:0]  nn_i;
   logic [15:0] ll_i;
   logic [7:0]  s_data_i;
   logic        s_valid_i;
   logic        s_ready_o;
   logic [7:0]  data_o;
   logic        valid_o;
   logic [1:0]  cmd_o;
   logic        ready_i;
   logic        hash_valid_i;
   logic [7:0]  hash_i;
   logic [7:0]  m_data_o;
   logic        m_valid_o;
   logic        done_o;
   logic        error_o;

   blake2_host_driver #(.TIMEOUT_CYCLES(4096)) dut (
      .clk(clk), .reset(reset), .start_i(start_i), .nn_i(nn_i), .ll_i(ll_i),
      .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
      .data_o(data_o), .valid_o(valid_o), .cmd_o(cmd_o), .ready_i(ready_i),
      .hash_valid_i(hash_valid_i), .hash_i(hash_i), .m_data_o(m_data_o),
      .m_valid_o(m_valid_o), .done_o(done_o), .error_o(error_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   typedef struct {
      int ll; int nn; int bp; int hv; int glitch;
      int exp_bytes; int exp_cmd1; int exp_dig; int exp_done; int exp_err; int exp_tmo;
   } vec_t;

   vec_t vecs[9];

   task automatic check_reset_vals();
      chk("rst data_o",    data_o,    0);
      chk("rst valid_o",   valid_o,   0);
      chk("rst cmd_o",     cmd_o,     0);
      chk("rst s_ready_o", s_ready_o, 0);
      chk("rst m_data_o",  m_data_o,  0);
      chk("rst m_valid_o", m_valid_o, 0);
      chk("rst done_o",    done_o,    0);
      chk("rst error_o",   error_o,   0);
   endtask

   task automatic run_txn(input vec_t v);
      logic [7:0] tx_d[$];
      logic [1:0] tx_c[$];
      logic [7:0] dg[$];
      logic [9:0] held_v;
      logic [7:0] exp_b;
      logic [1:0] exp_c;
      int src = 0, cyc = 0, hv_left, done_cnt = 0, stall_bad = 0, lat_bad = 0;
      int wait_cyc = -1, tmo_cyc = -1, done_bad = 0, post = 0, c1 = 0;
      bit hash_ph = 0, hv_prev = 0, held = 0, fin = 0, gl_done = 0;
      logic [7:0] cfg_exp[4];
      cfg_exp[0] = 8'h00;
      cfg_exp[1] = 8'(v.nn);
      cfg_exp[2] = 8'(v.ll);
      cfg_exp[3] = 8'(v.ll >> 8);
      @(posedge clk); #1;
      nn_i = 6'(v.nn); ll_i = 16'(v.ll); start_i = 1'b1; ready_i = 1'b1;
      s_valid_i = 1'b0; hash_valid_i = 1'b0;
      @(posedge clk); #1;
      start_i = 1'b0;
      chk("err_clear_on_start", error_o, 0);
      hv_left = v.hv;
      while (!fin && cyc < 8000) begin
         @(negedge clk);
         cyc++;
         if (held) begin
            if (!(valid_o && {cmd_o, data_o} == held_v)) stall_bad++;
            held = 0;
         end
         if (valid_o && !ready_i) begin held = 1; held_v = {cmd_o, data_o}; end
         if (valid_o && ready_i) begin tx_d.push_back(data_o); tx_c.push_back(cmd_o); end
         if (s_valid_i && s_ready_o) src++;
         if (hash_ph && (m_valid_o !== hv_prev)) lat_bad++;
         if (m_valid_o) dg.push_back(m_data_o);
         if (done_o) begin
            done_cnt++;
            if (!(m_valid_o && dg.size() == v.nn)) done_bad++;
         end
         if (wait_cyc >= 0) begin
            wait_cyc++;
            if (error_o && tmo_cyc < 0) tmo_cyc = wait_cyc;
         end
         if (wait_cyc < 0 && tx_d.size() == 4 + v.exp_bytes && !valid_o) wait_cyc = 0;
         hv_prev = hash_valid_i;
         @(posedge clk); #1;
         ready_i   = (v.bp != 0) ? ~ready_i : 1'b1;
         s_valid_i = (src < v.ll) && ((v.bp == 0) || ($urandom_range(0, 2) != 0));
         s_data_i  = 8'(8'h61 + src);
         hash_valid_i = 1'b0;
         if (v.glitch != 0 && src == 5 && !gl_done) begin hash_valid_i = 1'b1; gl_done = 1; end
         if (wait_cyc >= 2 && hv_left > 0) begin
            hash_valid_i = 1'b1;
            hash_i = 8'(8'hC0 + v.hv - hv_left);
            hv_left--;
            hash_ph = 1;
         end
         if (hash_ph && hv_left == 0 && !hash_valid_i) post++;
         if (post > 4) fin = 1;
         if (v.hv == 0 && tmo_cyc >= 0) fin = 1;
      end
      s_valid_i = 1'b0; hash_valid_i = 1'b0; ready_i = 1'b1;
      chk("txn_within_budget", fin, 1);
      chk("byte_count", tx_d.size(), 4 + v.exp_bytes);
      for (int i = 0; i < 4; i++)
         if (i < tx_d.size()) chk("cfg_byte", {tx_c[i], tx_d[i]}, {2'd0, cfg_exp[i]});
      for (int k = 0; k < v.exp_bytes; k++) begin
         if (4 + k < tx_d.size()) begin
            exp_b = (k < v.ll) ? 8'(8'h61 + k) : 8'h00;
            exp_c = (v.ll == 0 || (v.ll - 64 * (k / 64)) <= 64) ? 2'd2 : 2'd1;
            chk("data_byte_cmd", {tx_c[4+k], tx_d[4+k]}, {exp_c, exp_b});
            if (tx_c[4+k] == 2'd1) c1++;
         end
      end
      chk("cmd1_count", c1, v.exp_cmd1);
      chk("digest_count", dg.size(), v.exp_dig);
      for (int j = 0; j < dg.size(); j++) chk("digest_byte", dg[j], 8'(8'hC0 + j));
      chk("done_count", done_cnt, v.exp_done);
      chk("done_alignment", done_bad, 0);
      chk("stall_stable", stall_bad, 0);
      chk("digest_latency", lat_bad, 0);
      chk("error_flag", error_o, v.exp_err);
      if (v.exp_tmo != 0) chk("timeout_cycles", tmo_cyc, v.exp_tmo);
      repeat (2) @(posedge clk);
   endtask

   task automatic bad_nn(input logic [5:0] nn);
      int vbad = 0;
      @(posedge clk); #1;
      nn_i = nn; ll_i = 16'd3; start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      chk("bad_nn_error", error_o, 1);
      repeat (6) begin
         @(negedge clk);
         if (valid_o) vbad++;
      end
      chk("bad_nn_no_valid", vbad, 0);
   endtask

   initial begin
      int src, found;
      //              ll  nn bp hv gl bytes cmd1 dig done err tmo
      vecs[0] = '{   3, 32, 0, 32, 0,  64,   0, 32, 1, 0, 0};
      vecs[1] = '{  64, 16, 0, 16, 0,  64,   0, 16, 1, 0, 0};
      vecs[2] = '{  65, 32, 0, 32, 0, 128,  64, 32, 1, 0, 0};
      vecs[3] = '{   0,  1, 0,  1, 0,  64,   0,  1, 1, 0, 0};
      vecs[4] = '{  10,  8, 1,  8, 0,  64,   0,  8, 1, 0, 0};
      vecs[5] = '{   3,  8, 0,  5, 0,  64,   0,  5, 0, 1, 0};
      vecs[6] = '{  10,  4, 0,  4, 1,  64,   0,  4, 1, 1, 0};
      vecs[7] = '{   3,  4, 0,  0, 0,  64,   0,  0, 0, 1, 4096};
      vecs[8] = '{ 130,  4, 0,  4, 0, 192, 128,  4, 1, 0, 0};

      reset = 1'b1; start_i = 1'b0; nn_i = '0; ll_i = '0; s_data_i = '0;
      s_valid_i = 1'b0; ready_i = 1'b1; hash_valid_i = 1'b0; hash_i = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals();
      reset = 1'b0;

      for (int i = 0; i < 9; i++) run_txn(vecs[i]);

      bad_nn(6'd0);
      bad_nn(6'd33);

      // Reset while data byte 20 of a long message sits on the pins.
      @(posedge clk); #1;
      nn_i = 6'd4; ll_i = 16'd100; start_i = 1'b1; ready_i = 1'b1; s_valid_i = 1'b0;
      @(posedge clk); #1;
      start_i = 1'b0;
      src = 0; found = 0;
      for (int c = 0; c < 200 && found == 0; c++) begin
         @(negedge clk);
         if (s_valid_i && s_ready_o) src++;
         if (valid_o && cmd_o == 2'd1 && data_o == 8'h75) found = 1;
         else begin
            @(posedge clk); #1;
            s_valid_i = (src < 100);
            s_data_i  = 8'(8'h61 + src);
         end
      end
      chk("reached_data_byte_20", found, 1);
      #1 reset = 1'b1;
      #1;
      check_reset_vals();
      s_valid_i = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      run_txn(vecs[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
